// File: rtl/div_seq_if.sv
// Request/result bundle between the execute stage and the sequential divider.
// The master drives the operands and start; the slave returns status and results.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Works on magnitudes and applies the signs in a final FIX cycle.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    count;
  logic             q_neg, r_neg, zero;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             done_q, div_zero_q;

  logic             a_neg, b_neg, b_is_zero, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   prem_sh, trial;

  // NOTE: combinational blocks assign every output first, so no path can infer a latch.
  always_comb begin
    a_neg     = bus.signed_op & bus.a[WIDTH-1];
    b_neg     = bus.signed_op & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    b_is_zero = (bus.b == '0);
    // The partial remainder is always below the divisor, so WIDTH+1 bits
    // hold the shifted value and the MSB of the trial is its sign.
    prem_sh   = {prem, dividend[WIDTH-1]};
    trial     = prem_sh - {1'b0, divisor};
    last      = (count == CW'(1));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = b_is_zero ? FIX : RUN;
      RUN:     if (last) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend    <= '0;
      divisor     <= '0;
      prem        <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            zero     <= b_is_zero;
            // A zero divisor keeps the raw dividend, which becomes the remainder.
            dividend <= b_is_zero ? bus.a : a_mag;
            divisor  <= b_mag;
            prem     <= '0;
            count    <= CW'(WIDTH);
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
          end
        end
        RUN: begin
          prem     <= trial[WIDTH] ? prem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          dividend <= {dividend[WIDTH-2:0], ~trial[WIDTH]};
          count    <= count - CW'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          if (zero) begin
            quotient_q  <= '1;
            remainder_q <= dividend;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= q_neg ? -dividend : dividend;
            remainder_q <= r_neg ? -prem : prem;
            div_zero_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors, random operands against an
// arithmetic reference model, and hand-written busy/reset corner sequences.
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Truncating division computed with wide signed arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, sq, sr;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[W-1:0]; r = sr[W-1:0]; z = 1'b0;
    end
  endtask

  // Presents a request at the negedge; returns #1 after the accepting edge E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.signed_op = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.signed_op = 1'($urandom);
  endtask

  // Counts edges until done; lat stays -1 if the budget expires.
  task automatic wait_done(output int lat, output int busy_gaps);
    lat = -1; busy_gaps = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_gaps++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic z, input bit check_hold);
    int lat, gaps;
    start_op(a, b, s);
    check({name, ".busy_e0"}, bus.busy, 1);
    wait_done(lat, gaps);
    check({name, ".latency"}, lat, z ? 1 : W + 1);
    check({name, ".busy_gap"}, gaps, 0);
    check({name, ".busy_at_done"}, bus.busy, 0);
    check({name, ".quotient"}, bus.quotient, q);
    check({name, ".remainder"}, bus.remainder, r);
    check({name, ".div_zero"}, bus.div_zero, z);
    if (check_hold) begin
      @(posedge clk); #1;
      check({name, ".done_fall"}, bus.done, 0);
      check({name, ".q_hold"}, bus.quotient, q);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, eq, er;
    logic         rs, ez;
    int           lat, gaps, pulses;

    vecs[0] = '{"u100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0};
    vecs[1] = '{"s_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{"u_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b0, 32'h7FFF_FFFC, 32'd1,        1'b0};
    vecs[3] = '{"s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,        1'b0};
    vecs[4] = '{"u_max_1",  32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,        1'b0};
    vecs[5] = '{"zero_div", 32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[6] = '{"u9_3",     32'd9,          32'd3,          1'b0, 32'd3,        32'd0,        1'b0};
    vecs[7] = '{"s_7_m2",   32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        1'b0};

    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.quotient", bus.quotient, 0);
    check("reset.remainder", bus.remainder, 0);
    check("reset.div_zero", bus.div_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s,
                    vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      rs = 1'($urandom);
      model(ra, rb, rs, eq, er, ez);
      run_and_check($sformatf("rand%0d", i), ra, rb, rs, eq, er, ez, 1'b0);
    end

    // A start pulse at E10 must not disturb the in-flight 100/7.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.signed_op = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, gaps);
    check("ignore.latency", lat, W + 1 - 10);
    check("ignore.quotient", bus.quotient, 14);
    check("ignore.remainder", bus.remainder, 2);

    // Back-to-back: start raised in the done cycle.
    bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd5; bus.signed_op = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b.busy_e0", bus.busy, 1);
    check("b2b.done_e0", bus.done, 0);
    wait_done(lat, gaps);
    check("b2b.latency", lat, W + 1);
    check("b2b.quotient", bus.quotient, 10);
    check("b2b.remainder", bus.remainder, 0);

    // Asynchronous reset in the middle of a run.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.busy", bus.busy, 0);
    check("midrst.done", bus.done, 0);
    check("midrst.quotient", bus.quotient, 0);
    check("midrst.remainder", bus.remainder, 0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    check("midrst.no_done", pulses, 0);
    run_and_check("post_rst_20_6", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle integer divider paired with the ALU's single-cycle adder/subtractor. The adder computes sums and differences combinationally; this block performs the inverse of multiplication, producing quotient and remainder by radix-2 restoring division, one quotient bit per clock. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy`. Signed and unsigned division are both supported; divide-by-zero is flagged and produces defined results.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `signed_op`  in  1: 1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `a`  in  WIDTH: dividend; sampled with `start`.
- `b`  in  WIDTH: divisor; sampled with `start`.
- `busy`  out  1: high while a division is in progress.
- `done`  out  1: one-cycle pulse; results valid.
- `quotient`  out  WIDTH: result quotient; holds until the next completion.
- `remainder`  out  WIDTH: result remainder; holds until the next completion.
- `div_zero`  out  1: set with `done` when `b` was 0; holds until the next completion.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start`=1:
  - Latch the magnitudes of `a` and `b`. Negate only if `signed_op` is set and the MSB is 1.
  - Latch sign flags: quotient negative = sign(a) XOR sign(b); remainder negative = sign(a).
  - Clear the partial remainder. Load the bit counter with WIDTH.
  - If `b`==0, go to FIX with the zero flag set. Otherwise go to RUN.
- RUN, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the partial remainder, using WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. Go to FIX after the WIDTH-th iteration.
- FIX, one cycle:
  - Normal case: register the sign-corrected quotient and remainder, and set `div_zero`=0.
  - Zero divisor: `quotient`=all ones, `remainder`=original `a` unmodified, `div_zero`=1.
  - Pulse `done`. Return to IDLE.
- Signed overflow, most-negative / -1: the magnitude path yields `quotient`=most-negative and `remainder`=0, with no flag. This is the required result.
- Remainder is always 0 or has the sign of the dividend (truncating division).
- `start` while `busy` is ignored entirely: no latch and no effect on the in-flight operation.
- `a`, `b` and `signed_op` may change freely after the start edge.

## Timing
- Reset (async assert, any state): state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, all internal registers cleared.
- Reset release is synchronous to `clk`. The first `start` may be sampled on the first edge after release.
- Start accepted at edge E0: `busy` rises after E0.
- Normal divide:
  - RUN occupies edges E1..E(WIDTH).
  - FIX edge E(WIDTH+1) updates the outputs, raises `done`, and drops `busy`.
  - `done` falls at E(WIDTH+2).
  - Latency: WIDTH+1 edges (33 for WIDTH=32).
- Divide-by-zero: outputs and `done` update at E1. `busy` is high only between E0 and E1.
- `done` and `busy` are never high in the same cycle.
- A new `start` may be sampled in the cycle `done` is high, giving back-to-back operation with no dead cycle.
- Outputs change only at FIX edges or on reset.
- Reset mid-RUN aborts the operation. No `done` is produced and the outputs read 0.

## Test plan
- Unsigned, `a`=100, `b`=7: after start at E0, `done` at E33 with `quotient`=14, `remainder`=2, `div_zero`=0. `busy` high between E0 and E33.
- Signed, `a`=0xFFFFFFF9 (-7), `b`=2: `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1). Repeat with `signed_op`=0 to get `quotient`=0x7FFFFFFC, `remainder`=1.
- Signed overflow, `a`=0x80000000, `b`=0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0, `div_zero`=0. Also `a`=0xFFFFFFFF, `b`=1, unsigned: `quotient`=0xFFFFFFFF, `remainder`=0.
- Zero divisor, `a`=5, `b`=0: `done` at E1 with `quotient`=0xFFFFFFFF, `remainder`=5, `div_zero`=1. A following divide of 9/3 clears `div_zero` and gives `quotient`=3.
- `start` pulsed at E10 with different operands during a 100/7 run: ignored, result still 14 r 2. Then `start` asserted in the `done` cycle with 50/5: `quotient`=10 after a further 33 edges, with no idle gap.
- `rst_n` asserted low at E15 of a run: `busy`, `done`, `quotient` and `remainder` read 0 immediately, without waiting for a clock edge. No `done` pulse follows. After release, 20/6 yields `quotient`=3, `remainder`=2.
